// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
// IFQ_PREDECODE_EN adds a control-flow flag to every queue entry.
package if_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef IFQ_PREDECODE_EN
    logic        is_ctrl;
`endif
  } ifq_entry_t;

  function automatic logic is_ctrl_f(input logic [31:0] instr);
    logic [6:0] opc_s;
    logic       hit_s;
    opc_s = instr[6:0];
    case (opc_s)
      OPC_JAL, OPC_JALR, OPC_BRANCH: hit_s = 1'b1;
      default:                       hit_s = 1'b0;
    endcase
    return hit_s;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; clear wins over push/pop.
// The head entry is read straight out of the storage registers.
module if_fetch_fifo import if_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ifq_entry_t,
  parameter int  CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // guard against popping empty or pushing into a full queue
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  end

  // storage, pointers and fill level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/if_fetch_queue.sv
// Prefetching fetch stage: req/gnt/rvalid memory port, DEPTH-entry queue to decode.
// IFQ_PREDECODE_EN stores a control-flow flag per entry and drives o_is_ctrl.
module if_fetch_queue import if_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [31:0]     i_mem_rdata,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_instr_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_is_ctrl
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
`ifdef IFQ_PREDECODE_EN
    logic            is_ctrl;
`endif
  } entry_t;

  ifq_state_e      state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r, resp_pc_r, target_s;
  logic [CW-1:0]   outst_r, outst_nxt_s, discard_r, discard_nxt_s, count_s;
  logic [CW:0]     credit_s;
  logic            mem_req_s, fire_s, rv_ok_s, push_s, pop_s, instr_valid_s;
  entry_t          wr_entry_s, head_s;

  // handshake qualification and in-flight / discard bookkeeping
  always_comb begin
    target_s      = i_redirect_pc & ~XLEN'(3);
    instr_valid_s = (count_s != '0);
    credit_s      = {1'b0, count_s} + {1'b0, outst_r};
    fire_s        = mem_req_s && i_mem_gnt;
    rv_ok_s       = i_mem_rvalid && (outst_r != '0);
    push_s        = rv_ok_s && (discard_r == '0) && !i_redirect;
    pop_s         = instr_valid_s && i_instr_ready && !i_redirect;
    case ({fire_s, rv_ok_s})
      2'b10:   outst_nxt_s = outst_r + CW'(1);
      2'b01:   outst_nxt_s = outst_r - CW'(1);
      default: outst_nxt_s = outst_r;
    endcase
    // reads still outstanding after a redirect belong to the old path
    if (i_redirect) begin
      discard_nxt_s = outst_nxt_s;
    end else if (rv_ok_s && (discard_r != '0)) begin
      discard_nxt_s = discard_r - CW'(1);
    end else begin
      discard_nxt_s = discard_r;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= RUN;
    else          state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (i_redirect) begin
      state_nxt_s = (outst_nxt_s != '0) ? DRAIN : RUN;
    end else begin
      case (state_r)
        RUN:     state_nxt_s = RUN;
        DRAIN:   state_nxt_s = (discard_nxt_s == '0) ? RUN : DRAIN;
        default: state_nxt_s = RUN;
      endcase
    end
  end

  // FSM output: request only with a free queue slot reserved per read
  always_comb begin
    mem_req_s = i_rst_n && (state_r == RUN) && (outst_r < CW'(MAX_OUTST)) &&
                (credit_s < (CW + 1)'(DEPTH)) && !i_redirect;
  end

  // fetch/response PCs and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      outst_r    <= '0;
      discard_r  <= '0;
    end else begin
      outst_r   <= outst_nxt_s;
      discard_r <= discard_nxt_s;
      if (i_redirect) begin
        fetch_pc_r <= target_s;
        resp_pc_r  <= target_s;
      end else begin
        if (fire_s) fetch_pc_r <= fetch_pc_r + XLEN'(4);
        if (push_s) resp_pc_r  <= resp_pc_r + XLEN'(4);
      end
    end
  end

  // entry written on each accepted response
  always_comb begin
    wr_entry_s.pc    = resp_pc_r;
    wr_entry_s.instr = i_mem_rdata;
`ifdef IFQ_PREDECODE_EN
    wr_entry_s.is_ctrl = is_ctrl_f(i_mem_rdata);
`endif
  end

  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .CW      (CW)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .clear (i_redirect),
    .wdata (wr_entry_s),
    .rdata (head_s),
    .count (count_s)
  );

  assign o_mem_req     = mem_req_s;
  assign o_mem_addr    = fetch_pc_r;
  assign o_instr_valid = instr_valid_s;
  assign o_instr       = head_s.instr;
  assign o_pc          = head_s.pc;
`ifdef IFQ_PREDECODE_EN
  assign o_is_ctrl     = head_s.is_ctrl & instr_valid_s;
`else
  assign o_is_ctrl     = 1'b0;
`endif

endmodule
